// File: rtl/bmu_pipe.sv
// Bit-manipulation unit: single-cycle ALU ops (latency 1) plus iterative CLZ/CPOP (N+1 cycles).
// Registered output held under valid/ready backpressure; ready_out falls while busy or a held result is stalled.
module bmu_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result_out,
    output logic             error_out,
    output logic             busy,
    output logic [15:0]      err_count
);
    localparam int N   = WIDTH / CHUNK;
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int AW  = SHW + 1;

    typedef enum logic {IDLE, ITER} state_t;
    state_t state, state_nxt;

    logic             accept, iter_op, take_out, last_slice, iter_done, is_cpop, clz_done;
    logic [WIDTH-1:0] work, alu_res;
    logic             alu_err;
    logic [CW-1:0]    chunk_cnt;
    logic [AW-1:0]    clz_acc, cpop_acc, pop_s, lz_s, clz_add;
    logic [CHUNK-1:0] slice;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_ext, dif_ext;

    function automatic logic [AW-1:0] slice_pop(input logic [CHUNK-1:0] s);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) c = c + AW'(s[i]);
        return c;
    endfunction

    function automatic logic [AW-1:0] slice_lz(input logic [CHUNK-1:0] s);
        logic [AW-1:0] c;
        logic          seen;
        c    = '0;
        seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (s[i]) seen = 1'b1;
            else if (!seen) c = c + AW'(1);
        end
        return c;
    endfunction

    assign iter_op    = (op_in == 4'd11) || (op_in == 4'd12);
    assign accept     = valid_in && ready_out;
    assign take_out   = valid_out && ready_in;
    assign slice      = work[WIDTH-1 -: CHUNK];
    assign last_slice = (chunk_cnt == CW'(N - 1));
    assign pop_s      = slice_pop(slice);
    assign lz_s       = slice_lz(slice);
    assign clz_add    = clz_done ? '0 : lz_s;
    assign shamt      = b_in[SHW-1:0];
    assign sum_ext    = {a_in[WIDTH-1], a_in} + {b_in[WIDTH-1], b_in};
    assign dif_ext    = {a_in[WIDTH-1], a_in} - {b_in[WIDTH-1], b_in};

    always_ff @(posedge clk) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && iter_op) state_nxt = ITER;
            ITER:    if (last_slice) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // No skid buffer: acceptance is tied directly to the downstream ready.
    always_comb begin
        busy      = (state == ITER);
        iter_done = (state == ITER) && last_slice;
        ready_out = !busy && (!valid_out || ready_in);
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_in)
            4'd0:  begin alu_res = sum_ext[WIDTH-1:0]; alu_err = sum_ext[WIDTH] != sum_ext[WIDTH-1]; end
            4'd1:  begin alu_res = dif_ext[WIDTH-1:0]; alu_err = dif_ext[WIDTH] != dif_ext[WIDTH-1]; end
            4'd2:  alu_res = a_in & b_in;
            4'd3:  alu_res = a_in & ~b_in;
            4'd4:  alu_res = a_in ^ b_in;
            4'd5:  alu_res = a_in << shamt;
            4'd6:  alu_res = $signed(a_in) >>> shamt;
            4'd7:  alu_res = WIDTH'(a_in[shamt]);
            4'd8:  alu_res = WIDTH'($signed(a_in) < $signed(b_in));
            4'd9:  alu_res = WIDTH'(a_in < b_in);
            4'd10: alu_res = ($signed(a_in) < $signed(b_in)) ? a_in : b_in;
            4'd11, 4'd12: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            valid_out  <= 1'b0;
            result_out <= '0;
            error_out  <= 1'b0;
            err_count  <= '0;
            work       <= '0;
            chunk_cnt  <= '0;
            clz_acc    <= '0;
            cpop_acc   <= '0;
            clz_done   <= 1'b0;
            is_cpop    <= 1'b0;
        end else begin
            if (take_out && error_out && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;

            // The final slice is folded in combinationally so the result lands on the N-th edge.
            if (accept && !iter_op) begin
                result_out <= alu_res;
                error_out  <= alu_err;
                valid_out  <= 1'b1;
            end else if (iter_done) begin
                result_out <= is_cpop ? WIDTH'(cpop_acc + pop_s) : WIDTH'(clz_acc + clz_add);
                error_out  <= 1'b0;
                valid_out  <= 1'b1;
            end else if (take_out) begin
                valid_out  <= 1'b0;
            end

            if (accept && iter_op) begin
                work      <= a_in;
                chunk_cnt <= '0;
                clz_acc   <= '0;
                cpop_acc  <= '0;
                clz_done  <= 1'b0;
                is_cpop   <= (op_in == 4'd12);
            end else if (busy) begin
                work      <= work << CHUNK;
                chunk_cnt <= chunk_cnt + CW'(1);
                cpop_acc  <= cpop_acc + pop_s;
                clz_acc   <= clz_acc + clz_add;
                if (slice != '0) clz_done <= 1'b1;
            end
        end
    end
endmodule
